// File: rtl/receiver.sv
// UART 8N1 receiver: oversampled start-bit validation, mid-bit data sampling,
// and a holding register with ready / framing-error / overrun status.
module receiver #(
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    input  logic       sample_en,
    input  logic       ready_clr,
    output logic [7:0] data_out,
    output logic       ready,
    output logic       busy,
    output logic       frame_err,
    output logic       overrun
);

    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam logic [TICK_W-1:0] TICK_ZERO = TICK_W'(0);
    localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);
    localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    logic              rx_meta_r;
    logic              rx_sync_r;
    logic              rx_s;

    state_t            state_r;
    state_t            state_next_s;
    logic [TICK_W-1:0] tick_r;
    logic [TICK_W-1:0] tick_next_s;
    logic [2:0]        bit_r;
    logic [2:0]        bit_next_s;
    logic [7:0]        shift_r;
    logic [7:0]        shift_next_s;
    logic              done_s;

    logic [7:0]        data_r;
    logic [7:0]        data_next_s;
    logic              ready_r;
    logic              ready_next_s;
    logic              ferr_r;
    logic              ferr_next_s;
    logic              ovr_r;
    logic              ovr_next_s;
    logic              busy_r;
    logic              busy_next_s;

    // Two-flop synchronizer; idle-high reset value avoids a false start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
        end else begin
            rx_meta_r <= rx;
            rx_sync_r <= rx_meta_r;
        end
    end

    assign rx_s = rx_sync_r;

    // FSM state, tick/bit counters and shift register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            tick_r  <= TICK_ZERO;
            bit_r   <= 3'd0;
            shift_r <= 8'h00;
        end else begin
            state_r <= state_next_s;
            tick_r  <= tick_next_s;
            bit_r   <= bit_next_s;
            shift_r <= shift_next_s;
        end
    end

    // Next-state logic; everything advances only on oversample ticks.
    always_comb begin
        state_next_s = state_r;
        tick_next_s  = tick_r;
        bit_next_s   = bit_r;
        shift_next_s = shift_r;
        done_s       = 1'b0;
        if (sample_en) begin
            case (state_r)
                IDLE: begin
                    if (!rx_s) begin
                        state_next_s = START;
                        tick_next_s  = TICK_ZERO;
                    end else begin
                        state_next_s = IDLE;
                    end
                end
                START: begin
                    if (tick_r == TICK_MID) begin
                        tick_next_s = TICK_ZERO;
                        if (!rx_s) begin
                            state_next_s = DATA;
                            bit_next_s   = 3'd0;
                        end else begin
                            state_next_s = IDLE;
                        end
                    end else begin
                        tick_next_s = tick_r + TICK_ONE;
                    end
                end
                DATA: begin
                    if (tick_r == TICK_LAST) begin
                        shift_next_s[bit_r] = rx_s;
                        tick_next_s         = TICK_ZERO;
                        if (bit_r == 3'd7) begin
                            state_next_s = STOP;
                            bit_next_s   = 3'd0;
                        end else begin
                            bit_next_s = bit_r + 3'd1;
                        end
                    end else begin
                        tick_next_s = tick_r + TICK_ONE;
                    end
                end
                STOP: begin
                    if (tick_r == TICK_LAST) begin
                        done_s       = 1'b1;
                        state_next_s = IDLE;
                        tick_next_s  = TICK_ZERO;
                    end else begin
                        tick_next_s = tick_r + TICK_ONE;
                    end
                end
                default: begin
                    state_next_s = IDLE;
                    tick_next_s  = TICK_ZERO;
                    bit_next_s   = 3'd0;
                end
            endcase
        end else begin
            state_next_s = state_r;
        end
    end

    // Status/output next values; a completing frame takes priority over ready_clr.
    always_comb begin
        data_next_s  = data_r;
        ready_next_s = ready_r;
        ferr_next_s  = ferr_r;
        ovr_next_s   = ovr_r;
        busy_next_s  = (state_next_s != IDLE);
        if (done_s) begin
            data_next_s  = shift_r;
            ready_next_s = 1'b1;
            ferr_next_s  = ~rx_s;
            ovr_next_s   = ready_clr ? 1'b0 : (ovr_r | ready_r);
        end else if (ready_clr) begin
            ready_next_s = 1'b0;
            ovr_next_s   = 1'b0;
        end else begin
            ready_next_s = ready_r;
        end
    end

    // Registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_r  <= 8'h00;
            ready_r <= 1'b0;
            ferr_r  <= 1'b0;
            ovr_r   <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            data_r  <= data_next_s;
            ready_r <= ready_next_s;
            ferr_r  <= ferr_next_s;
            ovr_r   <= ovr_next_s;
            busy_r  <= busy_next_s;
        end
    end

    assign data_out  = data_r;
    assign ready     = ready_r;
    assign frame_err = ferr_r;
    assign overrun   = ovr_r;
    assign busy      = busy_r;

endmodule

// File: doc/receiver.md
Name: receiver

Overview:
UART receiver for the 8N1 protocol: 8 data bits, no parity, 1 stop bit, LSB first. It samples the serial rx line on an oversampling enable supplied by the shared baud generator and validates the start bit at mid-bit. It recovers each byte into a holding register and reports ready, framing-error and overrun status. It is the receive-side counterpart of the existing UART transmitter and sits between the rx pin and the host/bus logic.

Parameters:
OVERSAMPLE, 16, number of sample_en ticks per bit period; must be even and >= 4.

Ports:
clk  input  1  system clock, rising-edge active
rst_n  input  1  asynchronous active-low reset
rx  input  1  serial line, asynchronous to clk, idle high
sample_en  input  1  one-clk pulse at OVERSAMPLE x baud rate
ready_clr  input  1  host read acknowledge; clears ready and overrun
data_out  output  8  last received byte
ready  output  1  new byte available; sticky until ready_clr
busy  output  1  high while a frame is in reception (state != IDLE)
frame_err  output  1  stop bit of the last completed frame sampled low
overrun  output  1  a byte completed while ready was still set

Behaviour:
- Reset is asynchronous and active-low: one clock; reset is asynchronous and active-low.
- Reset values:
  - data_out=0x00, ready=0, frame_err=0, overrun=0, busy=0.
  - FSM=IDLE; tick and bit counters=0; synchronizer flops=1.
- rx passes through a 2-flop synchronizer (rx_s); all decisions use rx_s only.
- All state, counter and sampling updates occur only on cycles with sample_en=1, except the ready_clr and reset effects.
- FSM states IDLE, START, DATA, STOP:
  - IDLE: on sample_en with rx_s=0 -> START, tick_cnt=0.
  - START: tick_cnt increments per tick. At tick_cnt=OVERSAMPLE/2-1 (mid start bit), sample rx_s:
    - rx_s=0 -> DATA, tick_cnt=0, bit_idx=0.
    - rx_s=1 -> false start, return to IDLE; no status change.
  - DATA: at tick_cnt=OVERSAMPLE-1 (mid data bit), shift_reg[bit_idx]<=rx_s, tick_cnt=0, bit_idx+1. After bit_idx=7 is sampled -> STOP.
  - STOP: at tick_cnt=OVERSAMPLE-1 (mid stop bit):
    - data_out<=shift_reg, ready<=1, frame_err<=~rx_s.
    - overrun<=1 if ready was already 1 and ready_clr is not asserted this cycle.
    - -> IDLE.
- A byte is delivered even when frame_err=1.
- frame_err is refreshed by every completed frame; it is not sticky across frames.
- ready_clr=1: ready<=0 and overrun<=0 on the next clk edge, independent of sample_en.
- Simultaneous ready_clr and frame completion: completion wins, so ready=1 and overrun=0.
- Overrun: the new byte overwrites data_out; overrun stays 1 until ready_clr.
- Latency: ready rises on the clk edge of the sample_en that lands at mid stop bit, about 9.5 bit periods after the rx falling edge, plus 2 clk of synchronizer delay, plus at most 1 tick of detection jitter.
- Break (rx held low): each frame completes with data_out=0x00 and frame_err=1, then IDLE immediately re-detects a start.
- Reset mid-frame returns all state and outputs to their reset values. The next full frame after rst_n deasserts is received correctly. A partial frame in progress at deassert is resynchronized only once the line returns idle.
- Counter widths: tick_cnt = clog2(OVERSAMPLE) bits; bit_idx = 3 bits; no wrap beyond the defined terminal values.

Test Plan:
Bench setup: OVERSAMPLE=16, sample_en pulsed 1 clk in every 4, so 1 bit = 64 clk.
1. Single byte: drive a valid 8N1 frame carrying 0xA5 -> data_out=0xA5, ready=1, frame_err=0, overrun=0, within 9.5 bit periods + 6 clk of the start edge; busy=1 during the frame and 0 once ready rises.
2. Glitch: drive rx low for 3 ticks (12 clk), then high -> busy pulses high for 8 ticks and returns to 0; ready stays 0 and data_out is unchanged.
3. Framing error: send 0x3C with the stop bit driven low -> data_out=0x3C, ready=1, frame_err=1; a following good frame 0x3D -> frame_err=0.
4. Overrun: send 0x11 then 0x22 with no ready_clr -> data_out=0x22, ready=1, overrun=1; then pulse ready_clr for 1 clk -> ready=0, overrun=0 on the next edge.
5. Reset mid-frame: assert rst_n=0 during bit 3 of a frame -> all outputs go to reset values asynchronously; after release, send 0x5A -> data_out=0x5A, ready=1.
6. Back-to-back loopback: connect the existing transmitter to rx and send 0x00, 0xFF, 0x81 with ready_clr after each -> the three bytes are received in order with frame_err=0 and overrun=0 throughout.
